// File: rtl/clint_pkg.sv
// Shared offsets, reset constants and register-select decode for the riscy_clint peripheral.
package clint_pkg;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_MTIMECMP_LO,
    SEL_MTIMECMP_HI,
    SEL_MTIME_LO,
    SEL_MTIME_HI
  } reg_sel_e;

  // Word index is offset bits [15:2]; the byte lane bits never take part in decode.
  function automatic reg_sel_e decode_sel(input logic [13:0] word_idx);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (word_idx == MSIP_OFF[15:2])             sel = SEL_MSIP;
    else if (word_idx == MTIMECMP_LO_OFF[15:2]) sel = SEL_MTIMECMP_LO;
    else if (word_idx == MTIMECMP_HI_OFF[15:2]) sel = SEL_MTIMECMP_HI;
    else if (word_idx == MTIME_LO_OFF[15:2])    sel = SEL_MTIME_LO;
    else if (word_idx == MTIME_HI_OFF[15:2])    sel = SEL_MTIME_HI;
    return sel;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides clk by DIV to produce a one-cycle mtime tick; DIV = 1 ticks every cycle.
module clint_prescaler #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(DIV - 1));
  assign tick   = w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/riscy_clint.sv
// Core-local interruptor: mtime/mtimecmp/msip registers with timer and software interrupts.
// Optional CLINT_HI_LATCH_EN: a low-word mtime read snapshots the high word for a coherent 64-bit read.
module riscy_clint
  import clint_pkg::*;
#(
  parameter int          CLK_HZ    = 50000000,
  parameter int          TICK_HZ   = 1000000,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_addr,
  input  logic        clint_ren,
  input  logic        clint_wen,
  input  logic [31:0] wdata,
  output logic [31:0] clint_data_out,
  output logic        timer_irq,
  output logic        soft_irq
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  logic [31:0] w_off;
  logic        w_unused;
  reg_sel_e    w_sel;
  logic        w_tick;
  logic [31:0] w_mtime_hi_rd;
  logic [31:0] w_rdata;

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic [31:0] r_rdata;
  logic        r_timer_irq;
  logic        r_soft_irq;

  assign w_off    = data_addr - BASE_ADDR;
  assign w_sel    = decode_sel(w_off[15:2]);
  assign w_unused = ^{w_off[31:16], w_off[1:0]};

  clint_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  // A write to either mtime half pre-empts that cycle's increment entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime <= '0;
    end else if (clint_wen && (w_sel == SEL_MTIME_LO)) begin
      r_mtime[31:0] <= wdata;
    end else if (clint_wen && (w_sel == SEL_MTIME_HI)) begin
      r_mtime[63:32] <= wdata;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtimecmp <= MTIMECMP_RST;
      r_msip     <= 1'b0;
    end else if (clint_wen) begin
      if (w_sel == SEL_MTIMECMP_LO) r_mtimecmp[31:0]  <= wdata;
      if (w_sel == SEL_MTIMECMP_HI) r_mtimecmp[63:32] <= wdata;
      if (w_sel == SEL_MSIP)        r_msip            <= wdata[0];
    end
  end

`ifdef CLINT_HI_LATCH_EN
  logic [31:0] r_mtime_hi_shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime_hi_shadow <= '0;
    end else if (clint_wen && (w_sel == SEL_MTIME_HI)) begin
      r_mtime_hi_shadow <= wdata;
    end else if (clint_ren && (w_sel == SEL_MTIME_LO)) begin
      r_mtime_hi_shadow <= r_mtime[63:32];
    end
  end

  assign w_mtime_hi_rd = r_mtime_hi_shadow;
`else
  assign w_mtime_hi_rd = r_mtime[63:32];
`endif

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      SEL_MSIP:        w_rdata = {31'd0, r_msip};
      SEL_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
      SEL_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
      SEL_MTIME_LO:    w_rdata = r_mtime[31:0];
      SEL_MTIME_HI:    w_rdata = w_mtime_hi_rd;
      default:         w_rdata = '0;
    endcase
  end

  // Read data samples pre-edge register values, so a coinciding write is read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata     <= '0;
      r_timer_irq <= 1'b0;
      r_soft_irq  <= 1'b0;
    end else begin
      if (clint_ren) r_rdata <= w_rdata;
      r_timer_irq <= (r_mtime >= r_mtimecmp);
      r_soft_irq  <= r_msip;
    end
  end

  assign clint_data_out = r_rdata;
  assign timer_irq      = r_timer_irq;
  assign soft_irq       = r_soft_irq;

endmodule

// File: tb/tb_riscy_clint.sv
// Bench for riscy_clint: DIV=50 and DIV=1 instances share one bus, checked against a behavioural model.
module tb_riscy_clint;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_addr = BASE;
  logic        clint_ren = 1'b0;
  logic        clint_wen = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rd0, rd1;
  logic        ti0, ti1, si0, si1;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  riscy_clint u_dut50 (
    .clk(clk), .rst_n(rst_n), .data_addr(data_addr), .clint_ren(clint_ren),
    .clint_wen(clint_wen), .wdata(wdata), .clint_data_out(rd0),
    .timer_irq(ti0), .soft_irq(si0)
  );

  riscy_clint #(.CLK_HZ(1000000), .TICK_HZ(1000000)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_addr(data_addr), .clint_ren(clint_ren),
    .clint_wen(clint_wen), .wdata(wdata), .clint_data_out(rd1),
    .timer_irq(ti1), .soft_irq(si1)
  );

  // Behavioural model: index 0 is the DIV=50 instance, index 1 the DIV=1 instance.
  logic [63:0] m_mtime [2];
  logic [31:0] m_shadow[2];
  logic [31:0] m_rd    [2];
  logic        m_tirq  [2];
  logic        m_tick  [2];
  int          m_cnt   [2];
  logic [63:0] m_cmp;
  logic        m_msip;
  logic        m_sirq;

  function automatic int div_of(input int d);
    return (d == 0) ? 50 : 1;
  endfunction

  // 0 none, 1 msip, 2 cmp lo, 3 cmp hi, 4 mtime lo, 5 mtime hi
  function automatic int m_sel(input logic [31:0] a);
    logic [31:0] off;
    logic [15:0] o;
    off = a - BASE;
    o = {off[15:2], 2'b00};
    case (o)
      16'h0000: return 1;
      16'h4000: return 2;
      16'h4004: return 3;
      16'hBFF8: return 4;
      16'hBFFC: return 5;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input int d, input int s);
    case (s)
      1: return {31'd0, m_msip};
      2: return m_cmp[31:0];
      3: return m_cmp[63:32];
      4: return m_mtime[d][31:0];
`ifdef CLINT_HI_LATCH_EN
      5: return m_shadow[d];
`else
      5: return m_mtime[d][63:32];
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mtime[d] = '0; m_shadow[d] = '0; m_rd[d] = '0;
      m_tirq[d] = 1'b0; m_tick[d] = 1'b0; m_cnt[d] = 0;
    end
    m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    m_msip = 1'b0;
    m_sirq = 1'b0;
  endfunction

  // Drives one bus cycle, advances the model across the edge, returns 1 time unit after it.
  task automatic cyc(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] wd);
    int s;
    logic tk;
    clint_ren = ren; clint_wen = wen; data_addr = a; wdata = wd;
    @(posedge clk);
    s = m_sel(a);
    for (int d = 0; d < 2; d++) begin
      tk = (m_cnt[d] == div_of(d) - 1);
      m_tick[d] = tk;
      m_cnt[d] = tk ? 0 : m_cnt[d] + 1;
      m_tirq[d] = (m_mtime[d] >= m_cmp);
      if (ren) begin
        m_rd[d] = m_read(d, s);
        if (s == 4) m_shadow[d] = m_mtime[d][63:32];
      end
      if (wen && s == 4) m_mtime[d][31:0] = wd;
      else if (wen && s == 5) begin
        m_mtime[d][63:32] = wd;
        m_shadow[d] = wd;
      end else if (tk) m_mtime[d] = m_mtime[d] + 64'd1;
    end
    m_sirq = m_msip;
    if (wen && s == 1) m_msip = wd[0];
    if (wen && s == 2) m_cmp[31:0] = wd;
    if (wen && s == 3) m_cmp[63:32] = wd;
    edge_n++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, BASE, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clint_ren = 1'b0; clint_wen = 1'b0;
    #13;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (rd0 !== 32'd0 || ti0 !== 1'b0 || si0 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got rdata=%h tirq=%b sirq=%b expected 0/0/0", rd0, ti0, si0);
    end
    cyc(1'b1, 1'b0, BASE + 32'h4000, 32'd0);
    n_checks++;
    if (rd0 !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL reset_cmp_lo: got %h expected ffffffff", rd0);
    end
    cyc(1'b1, 1'b0, BASE + 32'h4004, 32'd0);
    n_checks++;
    if (rd0 !== 32'hFFFF_FFFF || ti0 !== 1'b0 || si0 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_cmp_hi: got %h tirq=%b sirq=%b expected ffffffff 0 0", rd0, ti0, si0);
    end
    $display("test_reset done");
  endtask

  task automatic test_count();
    do_reset();
    idle(7);
    cyc(1'b1, 1'b0, BASE + 32'hBFF8, 32'd0);
    n_checks++;
    if (rd1 !== 32'd7) begin
      n_errors++;
      $display("FAIL count_div1: got %0d expected 7", rd1);
    end
    idle(492);
    cyc(1'b1, 1'b0, BASE + 32'hBFF8, 32'd0);
    n_checks++;
    if (rd0 !== 32'd10) begin
      n_errors++;
      $display("FAIL count_div50: got %0d expected 10", rd0);
    end
    $display("test_count: div1=%0d div50=%0d", rd1, rd0);
  endtask

  task automatic test_msip();
    cyc(1'b0, 1'b1, BASE, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b0, BASE, 32'd0);
    n_checks++;
    if (rd0 !== 32'h1 || si0 !== 1'b1) begin
      n_errors++;
      $display("FAIL msip_set: got rdata=%h sirq=%b expected 00000001 1", rd0, si0);
    end
    cyc(1'b0, 1'b1, BASE + 32'h3, 32'd0);
    idle(1);
    n_checks++;
    if (si0 !== 1'b0) begin
      n_errors++;
      $display("FAIL msip_clear: got sirq=%b expected 0", si0);
    end
    $display("test_msip done");
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 1'b1, BASE + 32'h4000, 32'h1234_5678);
    n_checks++;
    if (rd0 !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL rbw_old: got %h expected ffffffff", rd0);
    end
    cyc(1'b1, 1'b0, BASE + 32'h4000, 32'd0);
    idle(3);
    n_checks++;
    if (rd0 !== 32'h1234_5678) begin
      n_errors++;
      $display("FAIL rbw_new_hold: got %h expected 12345678", rd0);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_timer();
    int ticks, k2, irq_edge, start;
    do_reset();
    cyc(1'b0, 1'b1, BASE + 32'h4004, 32'd1);
    cyc(1'b0, 1'b1, BASE + 32'h4000, 32'd0);
    cyc(1'b0, 1'b1, BASE + 32'hBFFC, 32'd0);
    cyc(1'b0, 1'b1, BASE + 32'hBFF8, 32'hFFFF_FFFE);
    ticks = 0; k2 = -1; irq_edge = -1; start = edge_n;
    while (irq_edge < 0 && edge_n - start < 200) begin
      idle(1);
      if (m_tick[0]) begin
        ticks++;
        if (ticks == 2) k2 = edge_n;
      end
      if (ti0 === 1'b1) irq_edge = edge_n;
    end
    n_checks++;
    if (irq_edge < 0 || k2 < 0 || irq_edge != k2 + 1) begin
      n_errors++;
      $display("FAIL timer_rise: got irq at edge %0d expected edge %0d", irq_edge, k2 + 1);
    end
    cyc(1'b1, 1'b0, BASE + 32'hBFFC, 32'd0);
    n_checks++;
    if (rd0 !== 32'd1) begin
      n_errors++;
      $display("FAIL timer_hi: got %h expected 00000001", rd0);
    end
    $display("test_timer: irq edge %0d second tick edge %0d", irq_edge, k2);
  endtask

  task automatic test_tick_write();
    cyc(1'b0, 1'b1, BASE + 32'hBFFC, 32'h0000_0ABC);
    for (int i = 0; i < 60 && m_cnt[0] != 49; i++) idle(1);
    cyc(1'b0, 1'b1, BASE + 32'hBFF8, 32'h55);
    cyc(1'b1, 1'b0, BASE + 32'hBFF8, 32'd0);
    n_checks++;
    if (rd0 !== 32'h55) begin
      n_errors++;
      $display("FAIL tick_write_lo: got %h expected 00000055", rd0);
    end
    cyc(1'b1, 1'b0, BASE + 32'hBFFC, 32'd0);
    n_checks++;
    if (rd0 !== 32'h0000_0ABC) begin
      n_errors++;
      $display("FAIL tick_write_hi: got %h expected 00000abc", rd0);
    end
    $display("test_tick_write done");
  endtask

  task automatic test_hi_latch();
    logic [31:0] exp_hi;
`ifdef CLINT_HI_LATCH_EN
    exp_hi = 32'd3;
`else
    exp_hi = 32'd4;
`endif
    for (int i = 0; i < 60 && m_cnt[0] != 0; i++) idle(1);
    cyc(1'b0, 1'b1, BASE + 32'hBFFC, 32'd3);
    cyc(1'b0, 1'b1, BASE + 32'hBFF8, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b0, BASE + 32'hBFF8, 32'd0);
    n_checks++;
    if (rd0 !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL hilatch_lo: got %h expected ffffffff", rd0);
    end
    idle(60);
    cyc(1'b1, 1'b0, BASE + 32'hBFFC, 32'd0);
    n_checks++;
    if (rd0 !== exp_hi) begin
      n_errors++;
      $display("FAIL hilatch_hi: got %h expected %h", rd0, exp_hi);
    end
    $display("test_hi_latch: hi=%h", rd0);
  endtask

  task automatic test_midreset();
    logic [31:0] exp_rd [7];
    logic [31:0] addrs  [7];
    cyc(1'b0, 1'b1, BASE, 32'd1);
    cyc(1'b0, 1'b1, BASE + 32'h4004, 32'd0);
    cyc(1'b1, 1'b0, BASE + 32'h4004, 32'd0);
    idle(2);
    rst_n = 1'b0;
    clint_ren = 1'b0; clint_wen = 1'b0;
    #3;
    n_checks++;
    if (rd0 !== 32'd0 || si0 !== 1'b0 || ti0 !== 1'b0 || ti1 !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_async: got rdata=%h sirq=%b tirq=%b/%b expected all 0", rd0, si0, ti0, ti1);
    end
    #10;
    model_reset();
    rst_n = 1'b1;
    addrs  = '{BASE, BASE + 32'h4000, BASE + 32'h4004, BASE + 32'hBFF8, BASE + 32'hBFFC,
               BASE + 32'hBFF8, BASE + 32'hBFF8};
    exp_rd = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd1};
    for (int i = 0; i < 7; i++) begin
      if (i == 5) idle(44);
      cyc(1'b1, 1'b0, addrs[i], 32'd0);
      n_checks++;
      if (rd0 !== exp_rd[i]) begin
        n_errors++;
        $display("FAIL midreset_read%0d: got %h expected %h", i, rd0, exp_rd[i]);
      end
    end
    $display("test_midreset done");
  endtask

  task automatic test_random();
    logic [31:0] a, wd;
    logic ren, wen;
    int k;
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 6);
      case (k)
        0: a = BASE;
        1: a = BASE + 32'h4000;
        2: a = BASE + 32'h4004;
        3: a = BASE + 32'hBFF8;
        4: a = BASE + 32'hBFFC;
        5: a = BASE + {16'd0, 16'($urandom)};
        default: a = BASE + {16'd0, 16'hBFF8} + 32'($urandom_range(0, 3));
      endcase
      wd = $urandom;
      if (k == 2 || k == 4) wd = $urandom_range(0, 2);
      ren = 1'($urandom_range(0, 1));
      wen = ($urandom_range(0, 3) == 0);
      cyc(ren, wen, a, wd);
      n_checks++;
      if (rd0 !== m_rd[0] || rd1 !== m_rd[1]) begin
        n_errors++;
        $display("FAIL rand_rdata cycle %0d: got %h/%h expected %h/%h", i, rd0, rd1, m_rd[0], m_rd[1]);
      end
      n_checks++;
      if (ti0 !== m_tirq[0] || ti1 !== m_tirq[1] || si0 !== m_sirq || si1 !== m_sirq) begin
        n_errors++;
        $display("FAIL rand_irq cycle %0d: got tirq=%b/%b sirq=%b/%b expected %b/%b %b",
                 i, ti0, ti1, si0, si1, m_tirq[0], m_tirq[1], m_sirq);
      end
    end
    $display("test_random: 400 cycles");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count();
    test_msip();
    test_back_to_back();
    test_timer();
    test_tick_write();
    test_hi_latch();
    test_midreset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
